// File: rtl/datapath_seq.sv
// datapath_seq: command-driven ALU datapath with a small register file.
// A command is accepted in IDLE, evaluated in EXEC and presented in DONE
// until the consumer takes it. The register file can also be loaded
// externally at any time, and a writeback to the same entry takes priority.
module datapath_seq #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int RW    = $clog2(NREGS),
    localparam int SEL_W = $clog2(NREGS + 4),
    localparam int CMD_W = 4 + 2 * SEL_W + RW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CMD_W-1:0]   cmd,
    input  logic [WIDTH-1:0]   din_a,
    input  logic [WIDTH-1:0]   din_b,
    input  logic               ld_en,
    input  logic [RW-1:0]      ld_addr,
    input  logic [WIDTH-1:0]   ld_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dout_high,
    output logic [WIDTH-1:0]   dout_low,
    output logic               zero,
    output logic               error,
    output logic [WIDTH-1:0]   op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q;
    logic [RW-1:0]        dst_q;
    logic                 wb_q;
    logic [WIDTH-1:0]     opa_q, opb_q;
    logic [WIDTH-1:0]     opa_d, opb_d;
    logic [WIDTH-1:0]     rf_q [NREGS];
    logic [2*WIDTH-1:0]   dout_q;
    logic                 zero_q, err_q;
    logic [WIDTH-1:0]     cnt_q;
    logic [2*WIDTH:0]     alu_w;
    logic [2*WIDTH-1:0]   res_w;
    logic                 res_err_w;
    logic                 accept_w;

    // Command field decode: {op, srca, srcb, dst, wb}, op at the MSB end.
    logic [3:0]       cmd_op;
    logic [SEL_W-1:0] cmd_srca, cmd_srcb;
    logic [RW-1:0]    cmd_dst;
    logic             cmd_wb;
    assign cmd_op   = cmd[CMD_W-1 -: 4];
    assign cmd_srca = cmd[CMD_W-5 -: SEL_W];
    assign cmd_srcb = cmd[CMD_W-5-SEL_W -: SEL_W];
    assign cmd_dst  = cmd[RW:1];
    assign cmd_wb   = cmd[0];

    // ALU: operands zero-extended to 2*WIDTH; returns {error, result}.
    function automatic logic [2*WIDTH:0] alu_f(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ax, bx, r;
        logic               e;
        ax = {{WIDTH{1'b0}}, a};
        bx = {{WIDTH{1'b0}}, b};
        r  = '0;
        e  = 1'b0;
        case (op)
            4'd0:  r = ax + bx;
            4'd1:  begin r = ax - bx; e = (a < b); end
            4'd2:  r = ax * bx;
            4'd3:  if (b == '0) e = 1'b1; else r = {a % b, a / b};
            4'd4:  r = ax & bx;
            4'd5:  r = ax | bx;
            4'd6:  r = ax ^ bx;
            4'd7:  r = {{WIDTH{1'b0}}, ~a};
            4'd8:  r = ax << b;
            4'd9:  r = ax >> b;
            4'd10: r = ax;
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    assign alu_w     = alu_f(op_q, opa_q, opb_q);
    assign res_w     = alu_w[2*WIDTH-1:0];
    assign res_err_w = alu_w[2*WIDTH];
    assign accept_w  = (state_q == IDLE) && cmd_valid;

    // Operand select for both sources: regfile, external inputs, or last result.
    always_comb begin
        opa_d = '0;
        opb_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (cmd_srca == SEL_W'(i)) opa_d = rf_q[i];
            if (cmd_srcb == SEL_W'(i)) opb_d = rf_q[i];
        end
        if (cmd_srca == SEL_W'(NREGS))     opa_d = din_a;
        if (cmd_srca == SEL_W'(NREGS + 1)) opa_d = din_b;
        if (cmd_srca == SEL_W'(NREGS + 2)) opa_d = dout_q[WIDTH-1:0];
        if (cmd_srca == SEL_W'(NREGS + 3)) opa_d = dout_q[2*WIDTH-1:WIDTH];
        if (cmd_srcb == SEL_W'(NREGS))     opb_d = din_a;
        if (cmd_srcb == SEL_W'(NREGS + 1)) opb_d = din_b;
        if (cmd_srcb == SEL_W'(NREGS + 2)) opb_d = dout_q[WIDTH-1:0];
        if (cmd_srcb == SEL_W'(NREGS + 3)) opb_d = dout_q[2*WIDTH-1:WIDTH];
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Controller next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid) state_d = EXEC;
            end
            EXEC: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, result/writeback on EXEC, external loads anytime.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            dst_q  <= '0;
            wb_q   <= 1'b0;
            opa_q  <= '0;
            opb_q  <= '0;
            dout_q <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            if (ld_en) rf_q[ld_addr] <= ld_data;
            if (accept_w) begin
                op_q  <= cmd_op;
                dst_q <= cmd_dst;
                wb_q  <= cmd_wb;
                opa_q <= opa_d;
                opb_q <= opb_d;
            end
            if (state_q == EXEC) begin
                dout_q <= res_w;
                err_q  <= res_err_w;
                zero_q <= (res_w == '0) && !res_err_w;
                cnt_q  <= cnt_q + 1'b1;
                // Placed after the load so a same-address writeback wins.
                if (wb_q && !res_err_w) rf_q[dst_q] <= res_w[WIDTH-1:0];
            end
        end
    end

    assign dout_high = dout_q[2*WIDTH-1:WIDTH];
    assign dout_low  = dout_q[WIDTH-1:0];
    assign zero      = zero_q;
    assign error     = err_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Randomised bench for datapath_seq with a behavioural reference model.
module tb_datapath_seq;
    localparam int W  = 8;
    localparam int NR = 4;
    localparam int RW = 2;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd = '0;
    logic [W-1:0]  din_a = '0, din_b = '0;
    logic          ld_en = 1'b0;
    logic [RW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  dout_high, dout_low, op_count;
    logic          zero, error;

    int n_vec = 0;
    int n_bad = 0;
    int mrf [NR];
    int mlo, mhi, mz, me, mcnt, ncmd;

    datapath_seq #(.WIDTH(W), .NREGS(NR)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .din_a(din_a), .din_b(din_b), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .out_valid(out_valid), .out_ready(out_ready), .dout_high(dout_high),
        .dout_low(dout_low), .zero(zero), .error(error), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU in plain integer arithmetic on 16-bit results.
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int r, output int e);
        r = 0;
        e = 0;
        case (op)
            0:  r = a + b;
            1:  begin r = (a - b) & 'hFFFF; e = (a < b) ? 1 : 0; end
            2:  r = a * b;
            3:  if (b == 0) e = 1; else r = (a % b) * 256 + a / b;
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = (~a) & 'hFF;
            8:  r = (b >= 16) ? 0 : ((a << b) & 'hFFFF);
            9:  r = a >> b;
            10: r = a;
            default: e = 1;
        endcase
    endfunction

    function automatic int operand(input int sel, input int a, input int b);
        if (sel < NR) return mrf[sel];
        if (sel == NR)     return a;
        if (sel == NR + 1) return b;
        if (sel == NR + 2) return mlo;
        if (sel == NR + 3) return mhi;
        return 0;
    endfunction

    task automatic check_out(input string p);
        chk({p, "_out_valid"}, out_valid, 1);
        chk({p, "_cmd_ready"}, cmd_ready, 0);
        chk({p, "_dout_high"}, dout_high, mhi);
        chk({p, "_dout_low"},  dout_low,  mlo);
        chk({p, "_zero"},      zero,      mz);
        chk({p, "_error"},     error,     me);
        chk({p, "_op_count"},  op_count,  mcnt);
    endtask

    task automatic ld_idle(input int addr, input int data);
        ld_en = 1'b1; ld_addr = RW'(addr); ld_data = W'(data);
        @(posedge clk); #1;
        ld_en = 1'b0;
        mrf[addr] = data;
    endtask

    task automatic do_cmd(input int op, input int sa, input int sb, input int dst, input int wb,
                          input int a, input int b, input int hold, input int junk,
                          input int lde, input int lda, input int ldd);
        int oa, ob, r, e;
        cmd = CW'((op << 9) | (sa << 6) | (sb << 3) | (dst << 1) | wb);
        din_a = W'(a); din_b = W'(b);
        cmd_valid = 1'b1; out_ready = 1'b1;
        chk("idle_cmd_ready", cmd_ready, 1);
        oa = operand(sa, a, b);
        ob = operand(sb, a, b);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        din_a = W'($urandom); din_b = W'($urandom);
        chk("exec_out_valid", out_valid, 0);
        chk("exec_cmd_ready", cmd_ready, 0);
        if (lde != 0) begin ld_en = 1'b1; ld_addr = RW'(lda); ld_data = W'(ldd); end
        if (hold > 0) out_ready = 1'b0;
        @(posedge clk); #1;
        ld_en = 1'b0;
        ref_alu(op, oa, ob, r, e);
        if (lde != 0) mrf[lda] = ldd;
        if (wb != 0 && e == 0) mrf[dst] = r & 'hFF;
        mlo = r & 'hFF; mhi = (r >> 8) & 'hFF; me = e;
        mz = (r == 0 && e == 0) ? 1 : 0;
        mcnt = (mcnt + 1) % 256;
        ncmd++;
        check_out("done");
        for (int i = 0; i < hold; i++) begin
            if (junk != 0) begin cmd_valid = 1'b1; cmd = CW'($urandom); end
            @(posedge clk); #1;
            check_out("hold");
        end
        cmd_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_ready_again", cmd_ready, 1);
        chk("idle_dout_low", dout_low, mlo);
        chk("idle_dout_high", dout_high, mhi);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) mrf[i] = 0;
        mlo = 0; mhi = 0; mz = 0; me = 0; mcnt = 0; ncmd = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout_high", dout_high, 0);
        chk("rst_dout_low", dout_low, 0);
        chk("rst_flags", {zero, error}, 0);
        chk("rst_op_count", op_count, 0);
        rst = 1'b0;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);

        // ADD 200+100 = 0x012C
        do_cmd(0, 4, 5, 0, 0, 200, 100, 0, 0, 0, 0, 0);
        chk("add_high", dout_high, 8'h01);
        chk("add_low", dout_low, 8'h2C);
        chk("add_count", op_count, 1);

        // MUL 255*255 writeback to reg2, then reg2 + din_b
        do_cmd(2, 4, 5, 2, 1, 255, 255, 0, 0, 0, 0, 0);
        chk("mul_res", {dout_high, dout_low}, 16'hFE01);
        do_cmd(0, 2, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("reg2_add", {dout_high, dout_low}, 16'h0002);

        // SUB underflow, DIV by zero without writeback, invalid op
        do_cmd(1, 4, 5, 0, 0, 3, 5, 0, 0, 0, 0, 0);
        chk("sub_res", {dout_high, dout_low}, 16'hFFFE);
        chk("sub_err", error, 1);
        ld_idle(0, 'h77);
        do_cmd(3, 4, 5, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        chk("div0_res", {dout_high, dout_low, zero, error}, 18'h1);
        do_cmd(10, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("div0_no_wb", dout_low, 8'h77);
        do_cmd(12, 4, 5, 0, 0, 9, 9, 0, 0, 0, 0, 0);
        chk("op12_err", error, 1);

        // Back-pressure with stray commands while busy
        do_cmd(6, 4, 5, 0, 0, 'hA5, 'h3C, 5, 1, 0, 0, 0);

        // Load/writeback collision, then load to another entry on the writeback edge
        do_cmd(10, 4, 5, 1, 1, 'h10, 0, 0, 0, 1, 1, 'h55);
        do_cmd(10, 4, 5, 0, 1, 'h22, 0, 0, 0, 1, 3, 'h66);
        do_cmd(10, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("collide_reg1", dout_low, 8'h10);
        do_cmd(10, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("load_reg3", dout_low, 8'h66);

        // Reset during EXEC aborts the command
        cmd = CW'((0 << 9) | (4 << 6) | (5 << 3) | (0 << 1) | 1);
        din_a = 8'd5; din_b = 8'd6; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_dout", {dout_high, dout_low}, 0);
        chk("mid_rst_flags", {zero, error}, 0);
        chk("mid_rst_op_count", op_count, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rel_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < NR; i++) mrf[i] = 0;
        mlo = 0; mhi = 0; mz = 0; me = 0; mcnt = 0; ncmd = 0;
        do_cmd(10, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_reg0", dout_low, 0);

        // Random commands until op_count wraps
        while (ncmd < 256) begin
            int op, sa, sb, b, lde;
            op  = $urandom_range(0, 15);
            sa  = $urandom_range(0, 7);
            sb  = $urandom_range(0, 7);
            b   = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 17);
            lde = ($urandom_range(0, 3) == 0) ? 1 : 0;
            do_cmd(op, sa, sb, $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 255), b, $urandom_range(0, 2), $urandom_range(0, 1),
                   lde, $urandom_range(0, 3), $urandom_range(0, 255));
        end
        chk("wrap_op_count", op_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
